// File: rtl/ledger_pkg.sv
// Shared types and constants for the vending-machine sales ledger:
// FSM state encoding, product id type and the per-product price table.
package ledger_pkg;

  localparam int NUM_PRODUCTS = 7;

  typedef logic [2:0] product_id_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    COMMIT = 3'd2,
    ACK    = 3'd3,
    ERR    = 3'd4
  } ledger_state_e;

  localparam logic [3:0] PRICE [1:NUM_PRODUCTS] = '{4'd2, 4'd3, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8};

  // Id 0 is not a product; it prices at zero so callers never index outside the table.
  function automatic logic [3:0] price_of(product_id_t id);
    logic [3:0] p;
    p = 4'd0;
    for (int i = 1; i <= NUM_PRODUCTS; i++) begin
      if (id == product_id_t'(i)) p = PRICE[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/num_scanner.sv
// Manager-view product index sequencer: 0 outside sales view, 1..7 cycling inside it.
// LEDGER_AUTOSCAN_EN lets scan_tick advance the index alongside step.
module num_scanner
  import ledger_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enm3,
  input  logic        step,
  input  logic        scan_tick,
  output product_id_t num
);

  logic        enm3_q;
  product_id_t num_q, num_d;
  logic        adv;

`ifdef LEDGER_AUTOSCAN_EN
  assign adv = step | scan_tick;
`else
  logic scan_en;
  assign scan_en = 1'b0;
  assign adv     = step | (scan_tick & scan_en);
`endif

  // Entering the view always restarts at product 1, even if an advance coincides.
  always_comb begin
    num_d = num_q;
    if (!enm3) begin
      num_d = '0;
    end else if (!enm3_q) begin
      num_d = product_id_t'(1);
    end else if (adv) begin
      num_d = (num_q == product_id_t'(NUM_PRODUCTS)) ? product_id_t'(1) : num_q + product_id_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enm3_q <= 1'b0;
      num_q  <= '0;
    end else begin
      enm3_q <= enm3;
      num_q  <= num_d;
    end
  end

  assign num = num_q;

endmodule

// File: rtl/sales_ledger.sv
// Sales bookkeeping controller: commits or rejects purchase requests, keeps per-product
// sold counts and turnover, and drives the manager view index (LEDGER_AUTOSCAN_EN in num_scanner).
//
// state  | meaning
// IDLE   | waiting for sale_req; honours clr when enm3=1
// CHECK  | validate latched id, view mode and overflow of count/turnover
// COMMIT | bump the product count and add the price to turnover
// ACK    | sale_ack held while sale_req stays high
// ERR    | sale_err held while sale_req stays high
module sales_ledger
  import ledger_pkg::*;
#(
  parameter int SELL_W = 5,
  parameter int TURN_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sale_req,
  input  logic [2:0]        sale_id,
  output logic              sale_ack,
  output logic              sale_err,
  input  logic              enm3,
  input  logic              step,
  input  logic              scan_tick,
  input  logic              clr,
  output logic [2:0]        num,
  output logic [SELL_W-1:0] sell1,
  output logic [SELL_W-1:0] sell2,
  output logic [SELL_W-1:0] sell3,
  output logic [SELL_W-1:0] sell4,
  output logic [SELL_W-1:0] sell5,
  output logic [SELL_W-1:0] sell6,
  output logic [SELL_W-1:0] sell7,
  output logic [TURN_W-1:0] turnover
);

  ledger_state_e     state_q, state_d;
  product_id_t       id_q;
  logic [SELL_W-1:0] sold_q [1:NUM_PRODUCTS];
  logic [SELL_W-1:0] sell_q [1:NUM_PRODUCTS];
  logic [TURN_W-1:0] turn_q;
  logic [TURN_W-1:0] turnover_q;
  logic              ack_q, err_q;

  logic              ld_id, clr_en, commit_en, ack_d, err_d;
  logic              clr_hit;
  logic [3:0]        price;
  logic [TURN_W:0]   turn_sum;
  logic              sold_full;

  assign clr_hit   = enm3 & clr;
  assign price     = price_of(id_q);
  assign turn_sum  = {1'b0, turn_q} + (TURN_W+1)'(price);
  assign sold_full = &sold_q[id_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // A carry out of turn_sum means the sale would push turnover past its limit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!clr_hit && sale_req) state_d = CHECK;
      end
      CHECK: begin
        if ((id_q == '0) || enm3 || sold_full || turn_sum[TURN_W]) state_d = ERR;
        else                                                       state_d = COMMIT;
      end
      COMMIT:   state_d = ACK;
      ACK, ERR: begin
        if (!sale_req) state_d = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    ld_id     = 1'b0;
    clr_en    = 1'b0;
    commit_en = 1'b0;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        clr_en = clr_hit;
        ld_id  = !clr_hit && sale_req;
      end
      COMMIT:  commit_en = 1'b1;
      ACK:     ack_d     = sale_req;
      ERR:     err_d     = sale_req;
      default: ;
    endcase
  end

  // Output copies lag the working ledger by one edge so every output is a plain register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q       <= '0;
      turn_q     <= '0;
      turnover_q <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 1; i <= NUM_PRODUCTS; i++) begin
        sold_q[i] <= '0;
        sell_q[i] <= '0;
      end
    end else begin
      if (ld_id) id_q <= sale_id;
      if (clr_en) begin
        turn_q <= '0;
        for (int i = 1; i <= NUM_PRODUCTS; i++) sold_q[i] <= '0;
      end else if (commit_en) begin
        turn_q       <= turn_sum[TURN_W-1:0];
        sold_q[id_q] <= sold_q[id_q] + SELL_W'(1);
      end
      for (int i = 1; i <= NUM_PRODUCTS; i++) sell_q[i] <= sold_q[i];
      turnover_q <= turn_q;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  num_scanner u_num_scanner (
    .clk       (clk),
    .rst_n     (rst_n),
    .enm3      (enm3),
    .step      (step),
    .scan_tick (scan_tick),
    .num       (num)
  );

  assign sale_ack = ack_q;
  assign sale_err = err_q;
  assign sell1    = sell_q[1];
  assign sell2    = sell_q[2];
  assign sell3    = sell_q[3];
  assign sell4    = sell_q[4];
  assign sell5    = sell_q[5];
  assign sell6    = sell_q[6];
  assign sell7    = sell_q[7];
  assign turnover = turnover_q;

endmodule

// File: tb/tb_sales_ledger.sv
// Directed bench for sales_ledger: scoreboard of expected sale outcomes, checked with
// immediate assertions when the DUT answers a request.
module tb_sales_ledger;

  logic       clk = 1'b0;
  logic       rst_n, sale_req, enm3, step, scan_tick, clr;
  logic [2:0] sale_id;
  logic       sale_ack, sale_err;
  logic [2:0] num;
  logic [4:0] sell1, sell2, sell3, sell4, sell5, sell6, sell7;
  logic [6:0] turnover;

  always #5 clk = ~clk;

  sales_ledger #(.SELL_W(5), .TURN_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .sale_req(sale_req), .sale_id(sale_id),
    .sale_ack(sale_ack), .sale_err(sale_err), .enm3(enm3), .step(step),
    .scan_tick(scan_tick), .clr(clr), .num(num),
    .sell1(sell1), .sell2(sell2), .sell3(sell3), .sell4(sell4),
    .sell5(sell5), .sell6(sell6), .sell7(sell7), .turnover(turnover)
  );

  typedef struct {
    int is_err;
    int id;
    int sell;
    int turn;
  } exp_t;

  localparam int PRICES [1:7] = '{2, 3, 3, 4, 5, 6, 8};

  exp_t sb[$];
  int   model_sell [1:7];
  int   model_turn;
  int   checks = 0;
  int   errors = 0;
  int   expn;

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int dut_sell(input int id);
    case (id)
      1: return int'(sell1);
      2: return int'(sell2);
      3: return int'(sell3);
      4: return int'(sell4);
      5: return int'(sell5);
      6: return int'(sell6);
      7: return int'(sell7);
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 1; i <= 7; i++) model_sell[i] = 0;
    model_turn = 0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 1; i <= 7; i++) chk($sformatf("%s_sell%0d", tag, i), dut_sell(i), 0);
    chk({tag, "_turn"}, int'(turnover), 0);
    chk({tag, "_num"},  int'(num), 0);
    chk({tag, "_ack"},  int'(sale_ack), 0);
    chk({tag, "_err"},  int'(sale_err), 0);
  endtask

  task automatic push_sale(input int id);
    exp_t e;
    int   bad;
    bad = (id == 0) || enm3;
    if (!bad) bad = (model_sell[id] == 31) || (model_turn + PRICES[id] > 127);
    if (!bad) begin
      model_sell[id] += 1;
      model_turn     += PRICES[id];
    end
    e.is_err = bad;
    e.id     = id;
    e.sell   = (id != 0) ? model_sell[id] : 0;
    e.turn   = model_turn;
    sb.push_back(e);
  endtask

  task automatic wait_resp(output int lat);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (sale_ack || sale_err) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic check_resp(input string tag, input int lat);
    exp_t e;
    e = sb.pop_front();
    chk({tag, "_latency"}, lat, e.is_err ? 3 : 4);
    chk({tag, "_ack"}, int'(sale_ack), e.is_err ? 0 : 1);
    chk({tag, "_err"}, int'(sale_err), e.is_err);
    if (e.id != 0) chk({tag, "_sell"}, dut_sell(e.id), e.sell);
    chk({tag, "_turn"}, int'(turnover), e.turn);
  endtask

  task automatic do_sale(input string tag, input int id);
    int lat;
    push_sale(id);
    sale_id  = 3'(id);
    sale_req = 1'b1;
    wait_resp(lat);
    check_resp(tag, lat);
    sale_req = 1'b0;
    @(negedge clk);
    chk({tag, "_drop"}, int'({sale_ack, sale_err}), 0);
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n = 1'b0; sale_req = 1'b0; sale_id = 3'd0; enm3 = 1'b0;
    step = 1'b0; scan_tick = 1'b0; clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("after_reset");

    do_sale("single_id3", 3);
    chk("single_sell3_const", int'(sell3), 1);
    chk("single_turn_const", int'(turnover), 3);
    do_sale("invalid_id0", 0);

    // Clear with view mode on, then a sale refused because the view is active.
    enm3 = 1'b1; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    model_reset();
    chk("clr_turn", int'(turnover), 0);
    chk("clr_sell3", int'(sell3), 0);
    chk("clr_num", int'(num), 1);
    do_sale("enm3_block", 2);
    enm3 = 1'b0;
    @(negedge clk);
    chk("enm3_off_num", int'(num), 0);

    for (int k = 0; k < 15; k++) do_sale($sformatf("fill7_%0d", k), 7);
    chk("fill_turn_120", int'(turnover), 120);
    chk("fill_sell7_15", int'(sell7), 15);
    do_sale("overflow_16th", 7);
    chk("overflow_sell7", int'(sell7), 15);

    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    chk("clr_ignored_turn", int'(turnover), 120);

    // Scanning sequence.
    enm3 = 1'b1;
    @(negedge clk);
    expn = 1;
    chk("scan_start", int'(num), expn);
    for (int k = 0; k < 8; k++) begin
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      expn = (expn == 7) ? 1 : expn + 1;
      chk($sformatf("scan_step_%0d", k), int'(num), expn);
    end
    step = 1'b1; scan_tick = 1'b1;
    @(negedge clk);
    step = 1'b0; scan_tick = 1'b0;
    expn = (expn == 7) ? 1 : expn + 1;
    chk("scan_both", int'(num), expn);
    scan_tick = 1'b1;
    @(negedge clk);
    scan_tick = 1'b0;
`ifdef LEDGER_AUTOSCAN_EN
    expn = (expn == 7) ? 1 : expn + 1;
`endif
    chk("scan_tick_only", int'(num), expn);
    @(negedge clk);
    chk("scan_hold", int'(num), expn);
    enm3 = 1'b0;
    @(negedge clk);
    chk("scan_exit", int'(num), 0);

    // Clear and request in the same IDLE cycle: clear wins, request then errors.
    enm3 = 1'b1; clr = 1'b1; sale_id = 3'd1; sale_req = 1'b1;
    model_reset();
    push_sale(1);
    @(negedge clk);
    clr = 1'b0;
    wait_resp(lat);
    check_resp("clr_race", lat);
    for (int i = 1; i <= 7; i++) chk($sformatf("clr_race_sell%0d", i), dut_sell(i), 0);
    sale_req = 1'b0;
    enm3 = 1'b0;
    repeat (2) @(negedge clk);

    do_sale("pre_rst_sale", 4);

    // Reset while the FSM sits in COMMIT.
    sale_id = 3'd1; sale_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_in_commit");
    sale_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    sb.delete();
    @(negedge clk);
    do_sale("post_rst_sale", 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
